// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the next-PC sequencer.
package pc_sequencer_pkg;

    localparam int unsigned PC_W_DEFAULT      = 8;
    localparam int unsigned RAS_DEPTH_DEFAULT = 4;

    // Sequencer state encoding as seen on the state output.
    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_HALT  = 2'b10,
        ST_FAULT = 2'b11
    } seq_state_e;

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// Return-address LIFO: DEPTH x W entries, pointer counts occupied slots.
module return_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] ptr;

    // Pointer moves on accepted push/pop; overflow/underflow requests are dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (push && !full) begin
            ptr <= ptr + PW'(1);
        end else if (pop && !empty) begin
            ptr <= ptr - PW'(1);
        end
    end

    // Entry storage needs no reset; only the pointer defines validity.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[ptr[AW-1:0]] <= push_data;
        end
    end

    assign top   = mem[AW'(ptr - PW'(1))];
    assign empty = (ptr == '0);
    assign full  = (ptr == PW'(DEPTH));

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: PC register, run/stall/halt/fault FSM and call/return stack.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned     PC_W         = PC_W_DEFAULT,
    parameter int unsigned     RAS_DEPTH    = RAS_DEPTH_DEFAULT,
    parameter logic [PC_W-1:0] RESET_VECTOR = PC_W'(0)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            halt_req,
    input  logic            resume,
    input  logic            branch,
    input  logic [PC_W-1:0] branch_offset,
    input  logic            jump,
    input  logic            call,
    input  logic            ret,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc,
    output logic [1:0]      state,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            fault
);

    seq_state_e      state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] ras_top;
    logic            ras_push;
    logic            ras_pop;
    logic            active;

    assign pc_inc = pc_q + PC_W'(1);
    assign active = ((state_q == ST_RUN) || (state_q == ST_STALL)) && !halt_req && !stall;

    // Stack requests follow the RUN priority: ret beats call, both blocked on fault conditions.
    always_comb begin
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        if (active) begin
            if (ret) begin
                ras_pop = !ras_empty;
            end else if (call) begin
                ras_push = !ras_full;
            end
        end
    end

    return_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_inc),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    // Sequencer FSM and next-PC selection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_VECTOR;
        end else begin
            case (state_q)
                ST_RUN, ST_STALL: begin
                    if (halt_req) begin
                        state_q <= ST_HALT;
                    end else if (stall) begin
                        state_q <= ST_STALL;
                    end else begin
                        state_q <= ST_RUN;
                        if (ret) begin
                            if (ras_empty) state_q <= ST_FAULT;
                            else           pc_q    <= ras_top;
                        end else if (call) begin
                            if (ras_full) state_q <= ST_FAULT;
                            else          pc_q    <= target;
                        end else if (jump) begin
                            pc_q <= target;
                        end else if (branch) begin
                            pc_q <= pc_q + branch_offset;
                        end else begin
                            pc_q <= pc_inc;
                        end
                    end
                end
                ST_HALT: begin
                    if (resume && !halt_req) state_q <= ST_RUN;
                end
                default: begin
                    state_q <= ST_FAULT;
                end
            endcase
        end
    end

    assign pc    = pc_q;
    assign state = state_q;
    assign fault = (state_q == ST_FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic against a queue-based model.
module tb_pc_sequencer;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       stall, halt_req, resume, branch, jump, call, ret;
    logic [7:0] branch_offset, target;
    logic [7:0] pc;
    logic [1:0] state;
    logic       ras_empty, ras_full, fault;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: PC value, mode code and stack as a queue.
    logic [7:0] m_pc;
    int         m_mode;
    logic [7:0] stk [$];

    pc_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall         (stall),
        .halt_req      (halt_req),
        .resume        (resume),
        .branch        (branch),
        .branch_offset (branch_offset),
        .jump          (jump),
        .call          (call),
        .ret           (ret),
        .target        (target),
        .pc            (pc),
        .state         (state),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        stall = 0; halt_req = 0; resume = 0; branch = 0; jump = 0; call = 0; ret = 0;
        branch_offset = 8'h00; target = 8'h00;
    endtask

    task automatic model_reset();
        m_pc = 8'h00;
        m_mode = 0;
        stk.delete();
    endtask

    // One clock of architectural behaviour: 0 RUN, 1 STALL, 2 HALT, 3 FAULT.
    task automatic model_step();
        if (m_mode == 0 || m_mode == 1) begin
            if (halt_req)   m_mode = 2;
            else if (stall) m_mode = 1;
            else begin
                m_mode = 0;
                if (ret) begin
                    if (stk.size() == 0) m_mode = 3;
                    else m_pc = stk.pop_back();
                end else if (call) begin
                    if (stk.size() == DEPTH) m_mode = 3;
                    else begin
                        stk.push_back(8'((int'(m_pc) + 1) % 256));
                        m_pc = target;
                    end
                end else if (jump) begin
                    m_pc = target;
                end else if (branch) begin
                    m_pc = 8'((int'(m_pc) + int'($signed(branch_offset)) + 256) % 256);
                end else begin
                    m_pc = 8'((int'(m_pc) + 1) % 256);
                end
            end
        end else if (m_mode == 2) begin
            if (resume && !halt_req) m_mode = 0;
        end
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".pc"},    32'(pc),        32'(m_pc));
        check_val({tag, ".state"}, 32'(state),     32'(m_mode));
        check_val({tag, ".empty"}, 32'(ras_empty), 32'(stk.size() == 0));
        check_val({tag, ".full"},  32'(ras_full),  32'(stk.size() == DEPTH));
        check_val({tag, ".fault"}, 32'(fault),     32'(m_mode == 3));
    endtask

    // Apply current inputs for one edge, then compare one time unit later.
    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse taken away from the clock edge.
    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic set_pc(input logic [7:0] v);
        idle_inputs();
        jump = 1; target = v;
        step("setpc");
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        model_reset();
        #3;
        check_all("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Idle counting from reset vector.
        for (int i = 1; i <= 5; i++) begin
            step("idle");
            check_val("idle_seq", 32'(pc), 32'(i));
        end

        // Mid-run reset is immediate.
        #2;
        do_reset("midreset");
        check_val("midreset_pc", 32'(pc), 32'h00);

        // Backward branch and wrap.
        set_pc(8'h10);
        branch = 1; branch_offset = 8'hF8;
        step("branch");
        check_val("branch_pc", 32'(pc), 32'h08);
        set_pc(8'hFF);
        step("wrap");
        check_val("wrap_pc", 32'(pc), 32'h00);
        set_pc(8'h02);
        branch = 1; branch_offset = 8'hFC;
        step("branch_wrap");
        check_val("branch_wrap_pc", 32'(pc), 32'hFE);

        // Call / return pair.
        set_pc(8'h05);
        call = 1; target = 8'h40;
        step("call");
        check_val("call_pc", 32'(pc), 32'h40);
        idle_inputs(); ret = 1;
        step("ret");
        check_val("ret_pc", 32'(pc), 32'h06);
        check_val("ret_empty", 32'(ras_empty), 32'h1);

        // Overflow to FAULT and freeze.
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            call = 1; target = 8'(8'h30 + 8'(i * 16));
            step("nest");
        end
        check_val("nest_full", 32'(ras_full), 32'h1);
        target = 8'hA0;
        step("overflow");
        check_val("overflow_state", 32'(state), 32'h3);
        check_val("overflow_pc", 32'(pc), 32'h60);
        idle_inputs();
        jump = 1; target = 8'h11; ret = 1;
        for (int i = 0; i < 3; i++) step("frozen");
        check_val("frozen_pc", 32'(pc), 32'h60);
        do_reset("fault_reset");

        // Underflow to FAULT.
        idle_inputs(); ret = 1;
        step("underflow");
        check_val("underflow_fault", 32'(fault), 32'h1);
        do_reset("uf_reset");

        // Halt beats call/jump; resume continues from held PC.
        set_pc(8'h20);
        halt_req = 1; call = 1; jump = 1; target = 8'h55;
        step("halt");
        check_val("halt_pc", 32'(pc), 32'h20);
        check_val("halt_empty", 32'(ras_empty), 32'h1);
        halt_req = 0;
        for (int i = 0; i < 3; i++) step("halted");
        halt_req = 1; resume = 1;
        step("halt_resume_both");
        check_val("both_state", 32'(state), 32'h2);
        idle_inputs(); resume = 1;
        step("resume");
        check_val("resume_pc", 32'(pc), 32'h20);
        idle_inputs();
        step("after_resume");
        check_val("after_resume_pc", 32'(pc), 32'h21);

        // Stall beats jump.
        stall = 1; jump = 1; target = 8'h80;
        step("stall");
        check_val("stall_state", 32'(state), 32'h1);
        check_val("stall_pc", 32'(pc), 32'h21);
        stall = 0;
        step("post_stall");
        check_val("post_stall_pc", 32'(pc), 32'h80);
        check_val("post_stall_state", 32'(state), 32'h0);

        // Random traffic with periodic resets.
        for (int c = 0; c < 3000; c++) begin
            if ((c % 250) == 249 || (m_mode == 3 && $urandom_range(0, 7) == 0)) begin
                idle_inputs();
                do_reset("rnd_reset");
            end else begin
                halt_req      = ($urandom_range(0, 19) == 0);
                resume        = ($urandom_range(0, 2) == 0);
                stall         = ($urandom_range(0, 9) == 0);
                ret           = ($urandom_range(0, 4) == 0);
                call          = ($urandom_range(0, 3) == 0);
                jump          = ($urandom_range(0, 4) == 0);
                branch        = ($urandom_range(0, 3) == 0);
                branch_offset = 8'($urandom);
                target        = 8'($urandom);
                step("rnd");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
